// File: rtl/lfsr_seeder_if.sv
// Seed handshake between a seed producer and lfsr_seeder.
// The producer holds seed_valid/seed_data; the seeder answers with seed_ready.
interface lfsr_seeder_if #(
  parameter int N = 8
);
  logic         seed_valid;
  logic         seed_ready;
  logic [N-1:0] seed_data;

  modport master (
    output seed_valid,
    output seed_data,
    input  seed_ready
  );

  modport slave (
    input  seed_valid,
    input  seed_data,
    output seed_ready
  );
endinterface

// File: rtl/lfsr_seeder.sv
// Serialises an accepted parallel seed into an LFSR (MSB first), then warms it up.
// Optional lockup auto-reseed is enabled by defining LFSR_SEEDER_LOCKUP_RESEED_EN.
module lfsr_seeder #(
  parameter int           N            = 8,
  parameter logic [N-1:0] DEFAULT_SEED = N'(1),
  parameter int           WARMUP       = 16
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_seeder_if.slave        seed_if,
  input  logic [N-1:0]        s_reg,
  output logic                load,
  output logic                s_reg_in,
  output logic                busy,
  output logic                seeded,
  output logic [7:0]          lockup_cnt
);

  localparam int BW = $clog2(N + 1);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] warm_cnt_q, warm_cnt_d;
  logic          ready_q, ready_d;
  logic          load_q, load_d;
  logic          sbit_q, sbit_d;
  logic          busy_q, busy_d;
  logic          seeded_q, seeded_d;
  logic          accept;
  logic          lockup;
  logic [N-1:0]  seed_eff;

  assign accept   = seed_if.seed_valid & ready_q;
  assign seed_eff = (seed_if.seed_data == '0) ? DEFAULT_SEED : seed_if.seed_data;

`ifdef LFSR_SEEDER_LOCKUP_RESEED_EN
  logic [7:0] lock_cnt_q, lock_cnt_d;

  assign lockup     = ((state_q == WARM) || (state_q == RUN)) && (s_reg == '0);
  assign lockup_cnt = lock_cnt_q;

  // A simultaneous user seed takes priority and does not count as a recovery.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lockup && !accept && (lock_cnt_q != 8'hFF)) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_s_reg;

  assign unused_s_reg = ^s_reg;
  assign lockup       = 1'b0;
  assign lockup_cnt   = 8'd0;
`endif

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    warm_cnt_d = warm_cnt_q;

    case (state_q)
      LOAD: begin
        if (bit_cnt_q == BIT_LAST) begin
          warm_cnt_d = '0;
          state_d    = (WARMUP == 0) ? RUN : WARM;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shadow_d  = shadow_q << 1;
        end
      end
      WARM: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d = RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A new seed or a lockup restarts the load from any non-LOAD state.
    if (accept) begin
      state_d   = LOAD;
      shadow_d  = seed_eff;
      bit_cnt_d = '0;
    end else if (lockup) begin
      state_d   = LOAD;
      shadow_d  = DEFAULT_SEED;
      bit_cnt_d = '0;
    end

    ready_d  = (state_d != LOAD);
    load_d   = (state_d == LOAD);
    busy_d   = (state_d == LOAD);
    sbit_d   = load_d & shadow_d[N-1];
    seeded_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      bit_cnt_q  <= '0;
      warm_cnt_q <= '0;
      ready_q    <= 1'b0;
      load_q     <= 1'b0;
      sbit_q     <= 1'b0;
      busy_q     <= 1'b0;
      seeded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      ready_q    <= ready_d;
      load_q     <= load_d;
      sbit_q     <= sbit_d;
      busy_q     <= busy_d;
      seeded_q   <= seeded_d;
    end
  end

  assign seed_if.seed_ready = ready_q;
  assign load               = load_q;
  assign s_reg_in           = sbit_q;
  assign busy               = busy_q;
  assign seeded             = seeded_q;

endmodule

// File: tb/tb_lfsr_seeder.sv
// Directed + randomized bench for lfsr_seeder driving a behavioural 8-bit LFSR.
// Expected bit streams and timing come from the seed value and the load/warm-up rules.
module tb_lfsr_seeder;

  localparam int          N      = 8;
  localparam int          WARMUP = 4;
  localparam logic [7:0]  DEFSD  = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_reg = 8'hFF;
  logic       load, s_reg_in, busy, seeded;
  logic [7:0] lockup_cnt;
  logic       zap = 1'b0;

  int checks   = 0;
  int failures = 0;

  lfsr_seeder_if #(.N(N)) seed_if ();

  lfsr_seeder #(
    .N           (N),
    .DEFAULT_SEED(DEFSD),
    .WARMUP      (WARMUP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_if   (seed_if),
    .s_reg     (s_reg),
    .load      (load),
    .s_reg_in  (s_reg_in),
    .busy      (busy),
    .seeded    (seeded),
    .lockup_cnt(lockup_cnt)
  );

  always #5 clk = ~clk;

  // Downstream LFSR: shifts s_reg_in in at bit 0 while loading, else x^8+x^6+x^5+x^4+1.
  always @(posedge clk) begin
    if (zap)       s_reg <= 8'h00;
    else if (load) s_reg <= {s_reg[6:0], s_reg_in};
    else           s_reg <= {s_reg[6:0], s_reg[7] ^ s_reg[5] ^ s_reg[4] ^ s_reg[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the first load cycle; leaves in the first cycle with load=0.
  task automatic load_phase(input logic [7:0] exp_seed, input string name);
    for (int k = 0; k < N; k++) begin
      chk("load_hi", load, 1'b1);
      chk("busy_hi", busy, 1'b1);
      chk("ready_lo", seed_if.seed_ready, 1'b0);
      chk("seeded_lo_load", seeded, 1'b0);
      chk("s_reg_in_bit", s_reg_in, exp_seed[N-1-k]);
      step();
    end
    chk("load_fall", load, 1'b0);
    chk("busy_fall", busy, 1'b0);
    chk("s_reg_loaded", s_reg, exp_seed);
    $display("load %s seed=%02h s_reg=%02h", name, exp_seed, s_reg);
  endtask

  task automatic warm_phase();
    for (int w = 0; w < WARMUP; w++) begin
      chk("warm_seeded_lo", seeded, 1'b0);
      chk("warm_ready", seed_if.seed_ready, 1'b1);
      chk("warm_load_lo", load, 1'b0);
      chk("warm_sbit_lo", s_reg_in, 1'b0);
      step();
    end
    chk("seeded_rise", seeded, 1'b1);
    $display("warm done seeded=%0b", seeded);
  endtask

  task automatic offer(input logic [7:0] d);
    seed_if.seed_valid = 1'b1;
    seed_if.seed_data  = d;
    step();
    seed_if.seed_valid = 1'b0;
  endtask

  function automatic logic [7:0] eff(input logic [7:0] d);
    return (d == 8'h00) ? DEFSD : d;
  endfunction

  initial begin
    logic [7:0] rs;
    seed_if.seed_valid = 1'b0;
    seed_if.seed_data  = 8'h00;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_load", load, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_seeded", seeded, 1'b0);
      chk("rst_ready", seed_if.seed_ready, 1'b0);
      chk("rst_sbit", s_reg_in, 1'b0);
      chk("rst_lockcnt", lockup_cnt, 8'd0);
    end
    reset = 1'b1;
    step();
    chk("post_rst_ready", seed_if.seed_ready, 1'b1);
    chk("post_rst_load", load, 1'b0);
    $display("reset released ready=%0b", seed_if.seed_ready);

    // Basic and zero seeds
    offer(8'hB4);
    load_phase(8'hB4, "basic");
    warm_phase();
    offer(8'h00);
    load_phase(eff(8'h00), "zero");
    warm_phase();

    // Reload from RUN with seed_valid held through the load
    offer(8'hB4);
    load_phase(8'hB4, "pre_reload");
    warm_phase();
    step();
    chk("run_seeded", seeded, 1'b1);
    seed_if.seed_valid = 1'b1;
    seed_if.seed_data  = 8'h3C;
    step();
    seed_if.seed_data  = 8'h77;
    load_phase(8'h3C, "reload");
    chk("held_ready", seed_if.seed_ready, 1'b1);
    step();
    seed_if.seed_valid = 1'b0;
    load_phase(8'h77, "held");
    warm_phase();

    // Randomized seeds with random dwell in RUN
    for (int r = 0; r < 8; r++) begin
      rs = 8'($urandom);
      if (r == 0) rs = 8'h00;
      offer(rs);
      load_phase(eff(rs), "random");
      warm_phase();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step();
        chk("dwell_seeded", seeded, 1'b1);
      end
    end

    // Reset in the middle of a load
    offer(8'hC3);
    for (int i = 0; i < 3; i++) begin
      chk("mid_load_hi", load, 1'b1);
      step();
    end
    reset = 1'b0;
    step();
    chk("midrst_load", load, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_seeded", seeded, 1'b0);
    reset = 1'b1;
    step();
    chk("midrst_ready", seed_if.seed_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_idle_seeded", seeded, 1'b0);
      chk("midrst_idle_load", load, 1'b0);
      step();
    end
    $display("reset mid-load seeded=%0b", seeded);

    offer(8'h96);
    load_phase(8'h96, "after_rst");
    warm_phase();

    // LFSR forced to all-zero while in RUN
    zap = 1'b1;
    step();
    zap = 1'b0;
`ifdef LFSR_SEEDER_LOCKUP_RESEED_EN
    step();
    chk("lock_cnt1", lockup_cnt, 8'd1);
    load_phase(DEFSD, "lockup");
    warm_phase();
    zap = 1'b1;
    step();
    zap = 1'b0;
    seed_if.seed_valid = 1'b1;
    seed_if.seed_data  = 8'h5A;
    step();
    seed_if.seed_valid = 1'b0;
    load_phase(8'h5A, "lockup_user");
    chk("lock_cnt_stay", lockup_cnt, 8'd1);
    warm_phase();
`else
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nolock_load", load, 1'b0);
      chk("nolock_seeded", seeded, 1'b1);
      chk("nolock_cnt", lockup_cnt, 8'd0);
      chk("nolock_sreg", s_reg, 8'h00);
    end
    $display("lockup left alone s_reg=%02h", s_reg);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
